// File: rtl/mips150_lsu_if.sv
// rtl/mips150_lsu_if.sv - request, DMEM and write-back signal bundle for mips150_lsu
interface mips150_lsu_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_rd, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, err
    );
endinterface

// File: rtl/mips150_lsu.sv
// rtl/mips150_lsu.sv - big-endian load/store unit; MIPS150_LSU_MISALIGN_TRAP_EN traps misaligned accesses
module mips150_lsu #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mips150_lsu_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  lsz_q, lsz_d;
    logic [1:0]  off_q, off_d;
    logic        sgn_q, sgn_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;

    logic        is_half, is_word, accept, issue;
    logic [1:0]  off;
    logic [31:0] shifted, ext;

    // Size 11 decodes as word; misaligned offsets are forced down to the access size.
    always_comb begin
        is_word = bus.req_size[1];
        is_half = (bus.req_size == 2'b01);
        off     = bus.req_addr[1:0];
        if (is_half) off[0] = 1'b0;
        if (is_word) off = 2'b00;
    end

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (is_half && bus.req_addr[0]) ||
                      (is_word && (bus.req_addr[1:0] != 2'b00));
    assign issue    = accept && !misalign;
`else
    assign issue    = accept;
`endif

    assign bus.mem_en   = issue;
    assign bus.mem_addr = bus.req_addr[ADDR_W-1:2];

    always_comb begin
        bus.mem_we    = 4'b0000;
        bus.mem_wdata = bus.req_wdata;
        if (is_half)
            bus.mem_wdata = {2{bus.req_wdata[15:0]}};
        else if (!is_word)
            bus.mem_wdata = {4{bus.req_wdata[7:0]}};
        if (issue && bus.req_we) begin
            if (is_word)      bus.mem_we = 4'b1111;
            else if (is_half) bus.mem_we = off[1] ? 4'b0011 : 4'b1100;
            else              bus.mem_we = 4'b1000 >> off;
        end
    end

    // Shifting the addressed lane to the top makes byte/half extraction offset-independent.
    always_comb begin
        shifted = bus.mem_rdata << {off_q, 3'b000};
        case (lsz_q)
            2'b00:   ext = {{24{sgn_q & shifted[31]}}, shifted[31:24]};
            2'b01:   ext = {{16{sgn_q & shifted[31]}}, shifted[31:16]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lsz_d      = lsz_q;
        off_d      = off_q;
        sgn_d      = sgn_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue && !bus.req_we) begin
                    state_d = WAIT;
                    cnt_d   = 2'(MEM_LAT - 1);
                    lsz_d   = is_word ? 2'b10 : {1'b0, is_half};
                    off_d   = off;
                    sgn_d   = bus.req_signed;
                    rd_d    = bus.req_rd;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ext;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
        err_d = accept && misalign;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            lsz_q      <= 2'd0;
            off_q      <= 2'd0;
            sgn_q      <= 1'b0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lsz_q      <= lsz_d;
            off_q      <= off_d;
            sgn_q      <= sgn_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.err      = err_q;
endmodule
